// File: rtl/door_if.sv
// Door controller signal bundle between dispatch/motion logic (master) and
// the car-door controller (slave).
interface door_if #(
  parameter int FLOORS  = 7,
  parameter int FLOOR_W = 3
);
  logic                 moving;
  logic [FLOOR_W-1:0]   currentFloor;
  logic [1:0]           currentDirection;
  logic [1:0]           currentFloorButton;
  logic [FLOORS+2:1]    internalButton;
  logic                 obstruction;
  logic                 doorState;
  logic [1:0]           doorPhase;
  logic                 serviced;
  logic                 fault;

  modport master (
    output moving,
    output currentFloor,
    output currentDirection,
    output currentFloorButton,
    output internalButton,
    output obstruction,
    input  doorState,
    input  doorPhase,
    input  serviced,
    input  fault
  );

  modport slave (
    input  moving,
    input  currentFloor,
    input  currentDirection,
    input  currentFloorButton,
    input  internalButton,
    input  obstruction,
    output doorState,
    output doorPhase,
    output serviced,
    output fault
  );
endinterface

// File: rtl/door_controller.sv
// Car-door controller: opens on a call at the current floor, dwells, closes,
// reverses on obstruction and falls back to a nudge (no-reverse) mode with fault.
module door_controller #(
  parameter int FLOORS       = 7,
  parameter int FLOOR_W      = 3,
  parameter int CLK_PER_OPEN = 500000000,
  parameter int CLK_PER_MOVE = 50000000,
  parameter int MAX_REOPEN   = 3
) (
  input logic  clk,
  input logic  reset,
  door_if.slave door
);

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } phaseT;

  localparam int                  REOPEN_W     = $clog2(MAX_REOPEN + 1);
  localparam logic [31:0]         OPEN_RELOAD  = 32'(CLK_PER_OPEN - 1);
  localparam logic [31:0]         MOVE_RELOAD  = 32'(CLK_PER_MOVE - 1);
  localparam logic [REOPEN_W-1:0] REOPEN_LIMIT = REOPEN_W'(MAX_REOPEN);
  localparam logic [REOPEN_W-1:0] REOPEN_ONE   = REOPEN_W'(1);

  phaseT               phaseR;
  phaseT               phaseNext;
  logic [31:0]         timerR;
  logic [31:0]         timerNext;
  logic [REOPEN_W-1:0] reopenR;
  logic [REOPEN_W-1:0] reopenNext;
  logic                servicedR;
  logic                servicedNext;
  logic                faultR;
  logic                faultNext;

  logic                carCall;
  logic                hallCall;
  logic                openReq;
  logic                closeReq;

  // Request decode; a floor index outside 1..FLOORS selects no car call.
  always_comb begin
    carCall = 1'b0;
    for (int f = 1; f <= FLOORS; f++) begin
      if (door.currentFloor == FLOOR_W'(f)) begin
        carCall = carCall | door.internalButton[f];
      end else begin
        carCall = carCall;
      end
    end
    if (door.currentDirection != 2'b00) begin
      hallCall = (door.currentFloorButton & door.currentDirection) != 2'b00;
    end else begin
      hallCall = 1'b0;
    end
    openReq  = hallCall | carCall | door.internalButton[FLOORS+2];
    closeReq = door.internalButton[FLOORS+1];
  end

  // Next-state and next-output logic for the door phase machine.
  always_comb begin
    phaseNext    = phaseR;
    timerNext    = timerR;
    reopenNext   = reopenR;
    servicedNext = 1'b0;
    faultNext    = faultR;
    case (phaseR)
      CLOSED: begin
        if (openReq && !door.moving) begin
          phaseNext = OPENING;
          timerNext = MOVE_RELOAD;
        end else begin
          phaseNext = CLOSED;
        end
      end
      OPENING: begin
        if (timerR == 32'd0) begin
          phaseNext    = OPEN;
          timerNext    = OPEN_RELOAD;
          servicedNext = 1'b1;
        end else begin
          timerNext = timerR - 32'd1;
        end
      end
      OPEN: begin
        if (door.obstruction || openReq) begin
          timerNext = OPEN_RELOAD;
        end else if (closeReq || (timerR == 32'd0)) begin
          phaseNext = CLOSING;
          timerNext = MOVE_RELOAD;
        end else begin
          timerNext = timerR - 32'd1;
        end
      end
      CLOSING: begin
        // Reversal reopens only as far as the door has already closed.
        if (!faultR && (door.obstruction || openReq)) begin
          phaseNext = OPENING;
          timerNext = MOVE_RELOAD - timerR;
          if (reopenR != REOPEN_LIMIT) begin
            reopenNext = reopenR + REOPEN_ONE;
          end else begin
            reopenNext = reopenR;
          end
          if (reopenR >= (REOPEN_LIMIT - REOPEN_ONE)) begin
            faultNext = 1'b1;
          end else begin
            faultNext = faultR;
          end
        end else if (faultR && door.obstruction) begin
          timerNext = timerR;
        end else if (timerR == 32'd0) begin
          phaseNext  = CLOSED;
          reopenNext = '0;
          faultNext  = 1'b0;
        end else begin
          timerNext = timerR - 32'd1;
        end
      end
      default: begin
        phaseNext = CLOSED;
        timerNext = 32'd0;
      end
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      phaseR    <= CLOSED;
      timerR    <= 32'd0;
      reopenR   <= '0;
      servicedR <= 1'b0;
      faultR    <= 1'b0;
    end else begin
      phaseR    <= phaseNext;
      timerR    <= timerNext;
      reopenR   <= reopenNext;
      servicedR <= servicedNext;
      faultR    <= faultNext;
    end
  end

  assign door.doorPhase = phaseR;
  assign door.doorState = (phaseR != CLOSED);
  assign door.serviced  = servicedR;
  assign door.fault     = faultR;

endmodule

// File: tb/tb_door_controller.sv
// Scoreboard bench for door_controller: directed scenarios plus random traffic
// checked cycle by cycle against a phase/remaining-cycles reference model.
module tb_door_controller;
  localparam int FLOORS = 7;
  localparam int FLOOR_W = 3;
  localparam int T_OPEN = 8;
  localparam int T_MOVE = 4;
  localparam int MAX_RO = 2;

  localparam logic [1:0] P_CLOSED  = 2'b00;
  localparam logic [1:0] P_OPENING = 2'b01;
  localparam logic [1:0] P_OPEN    = 2'b10;
  localparam logic [1:0] P_CLOSING = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  door_if #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) dif ();

  door_controller #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .CLK_PER_OPEN(T_OPEN),
    .CLK_PER_MOVE(T_MOVE), .MAX_REOPEN(MAX_RO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .door(dif)
  );

  typedef struct packed {
    logic       ds;
    logic [1:0] ph;
    logic       svc;
    logic       flt;
  } expT;

  expT expQ[$];
  int checks = 0;
  int failures = 0;

  // reference model: phase plus cycles left in that phase
  logic [1:0] mPhase = P_CLOSED;
  int mLeft = 0;
  int mReopen = 0;
  logic mFault = 1'b0;
  logic mSvc = 1'b0;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit hall, car, openR, closeR;
    int fl;
    logic [1:0] dir, btn;
    dir = dif.currentDirection;
    btn = dif.currentFloorButton;
    hall = (dir == 2'b10 && btn[1]) || (dir == 2'b01 && btn[0]) || (dir == 2'b11 && btn != 2'b00);
    fl = int'(dif.currentFloor);
    car = (fl >= 1 && fl <= FLOORS) ? dif.internalButton[fl] : 1'b0;
    openR = hall || car || dif.internalButton[FLOORS+2];
    closeR = dif.internalButton[FLOORS+1];
    mSvc = 1'b0;
    if (reset) begin
      mPhase = P_CLOSED; mLeft = 0; mReopen = 0; mFault = 1'b0;
    end else begin
      case (mPhase)
        P_CLOSED: if (openR && !dif.moving) begin mPhase = P_OPENING; mLeft = T_MOVE; end
        P_OPENING: begin
          mLeft--;
          if (mLeft == 0) begin mPhase = P_OPEN; mLeft = T_OPEN; mSvc = 1'b1; end
        end
        P_OPEN: begin
          if (dif.obstruction || openR) mLeft = T_OPEN;
          else if (closeR || mLeft == 1) begin mPhase = P_CLOSING; mLeft = T_MOVE; end
          else mLeft--;
        end
        default: begin
          if (!mFault && (dif.obstruction || openR)) begin
            // reopen takes as long as the closing travel completed so far
            mLeft = T_MOVE - mLeft + 1;
            mPhase = P_OPENING;
            mReopen++;
            if (mReopen >= MAX_RO) mFault = 1'b1;
          end else if (mFault && dif.obstruction) begin
            mLeft = mLeft;
          end else if (mLeft == 1) begin
            mPhase = P_CLOSED; mLeft = 0; mReopen = 0; mFault = 1'b0;
          end else begin
            mLeft--;
          end
        end
      endcase
    end
  endtask

  task automatic step();
    expT e;
    modelStep();
    e.ds = (mPhase != P_CLOSED);
    e.ph = mPhase;
    e.svc = mSvc;
    e.flt = mFault;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic clearIn();
    reset = 1'b0;
    dif.moving = 1'b0;
    dif.currentFloor = 3'd3;
    dif.currentDirection = 2'b00;
    dif.currentFloorButton = 2'b00;
    dif.internalButton = '0;
    dif.obstruction = 1'b0;
  endtask

  task automatic waitPhase(input logic [1:0] p);
    int n = 0;
    while (mPhase != p && n < 100) begin step(); n++; end
  endtask

  task automatic carCall3();
    dif.internalButton[3] = 1'b1;
    step();
    dif.internalButton[3] = 1'b0;
  endtask

  // Monitor: compare every post-edge DUT output against the queued expectation.
  initial begin
    expT e, got;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        got.ds = dif.doorState; got.ph = dif.doorPhase;
        got.svc = dif.serviced; got.flt = dif.fault;
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got ds=%b ph=%b svc=%b flt=%b expected ds=%b ph=%b svc=%b flt=%b",
                   $time, got.ds, got.ph, got.svc, got.flt, e.ds, e.ph, e.svc, e.flt);
        end
      end
    end
  end

  initial begin
    int dsCount, svcCount, cnt;
    clearIn();
    reset = 1'b1;
    @(negedge clk);
    step(); step();
    reset = 1'b0;
    step();

    // car call: 16 cycles door open, one serviced pulse
    carCall3();
    dsCount = 0; svcCount = 0;
    for (int i = 0; i < 22; i++) begin
      dsCount += int'(dif.doorState);
      svcCount += int'(dif.serviced);
      step();
    end
    check("s1_door_high_cycles", dsCount, 16);
    check("s1_serviced_pulses", svcCount, 1);

    // hall call match / mismatch
    dif.currentDirection = 2'b10; dif.currentFloorButton = 2'b01;
    repeat (3) step();
    check("s2_mismatch_closed", int'(dif.doorPhase), int'(P_CLOSED));
    dif.currentFloorButton = 2'b10;
    step();
    dif.currentFloorButton = 2'b00;
    check("s2_match_opening", int'(dif.doorPhase), int'(P_OPENING));
    waitPhase(P_CLOSED);
    dif.currentDirection = 2'b00; dif.currentFloorButton = 2'b11;
    repeat (3) step();
    check("s2_stop_closed", int'(dif.doorPhase), int'(P_CLOSED));
    dif.currentFloorButton = 2'b00;

    // open button held in OPEN, then 8 more OPEN cycles
    carCall3();
    waitPhase(P_OPEN);
    dif.internalButton[FLOORS+2] = 1'b1;
    repeat (20) step();
    dif.internalButton[FLOORS+2] = 1'b0;
    cnt = 0;
    while (dif.doorPhase == P_OPEN && cnt < 50) begin step(); cnt++; end
    check("s3_open_tail", cnt, T_OPEN);
    waitPhase(P_CLOSED);

    // close pulse on 2nd OPEN cycle
    carCall3();
    waitPhase(P_OPEN);
    step();
    dif.internalButton[FLOORS+1] = 1'b1;
    step();
    dif.internalButton[FLOORS+1] = 1'b0;
    check("s3_close_next", int'(dif.doorPhase), int'(P_CLOSING));
    waitPhase(P_CLOSED);

    // moving blocks opening
    dif.moving = 1'b1; dif.internalButton[3] = 1'b1;
    repeat (5) step();
    check("s3_moving_closed", int'(dif.doorPhase), int'(P_CLOSED));
    dif.moving = 1'b0; dif.internalButton[3] = 1'b0;

    // reversal at closing timer=1: 3-cycle reopen, serviced again
    carCall3();
    waitPhase(P_CLOSING);
    step(); step();
    dif.obstruction = 1'b1;
    step();
    dif.obstruction = 1'b0;
    cnt = 0;
    while (dif.doorPhase == P_OPENING && cnt < 20) begin step(); cnt++; end
    check("s4_reopen_len", cnt, 3);
    check("s4_reserviced", int'(dif.serviced), 1);
    waitPhase(P_CLOSED);
    step();

    // nudge mode after two reversals
    carCall3();
    waitPhase(P_CLOSING);
    dif.obstruction = 1'b1; step(); dif.obstruction = 1'b0;
    check("s5_fault_first", int'(dif.fault), 0);
    waitPhase(P_CLOSING);
    dif.obstruction = 1'b1; step(); dif.obstruction = 1'b0;
    check("s5_fault_set", int'(dif.fault), 1);
    waitPhase(P_CLOSING);
    dif.obstruction = 1'b1; dif.internalButton[FLOORS+2] = 1'b1;
    repeat (5) step();
    check("s5_paused", int'(dif.doorPhase), int'(P_CLOSING));
    dif.obstruction = 1'b0; dif.internalButton[FLOORS+2] = 1'b0;
    cnt = 0;
    while (dif.doorPhase == P_CLOSING && cnt < 20) begin step(); cnt++; end
    check("s5_close_len", cnt, 4);
    check("s5_fault_clear", int'(dif.fault), 0);

    // reset mid-OPENING and mid-CLOSING
    carCall3();
    step();
    reset = 1'b1; step(); reset = 1'b0;
    check("s6_reset_opening", {dif.doorState, dif.doorPhase, dif.serviced, dif.fault}, 0);
    carCall3();
    cnt = 0;
    while (dif.doorPhase == P_OPENING && cnt < 20) begin step(); cnt++; end
    check("s6_full_opening", cnt, T_MOVE);
    waitPhase(P_CLOSING);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    check("s6_reset_closing", {dif.doorState, dif.doorPhase, dif.serviced, dif.fault}, 0);
    step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 300) == 0;
      dif.moving = ($urandom % 8) == 0;
      dif.currentFloor = 3'($urandom_range(0, 7));
      dif.currentDirection = 2'($urandom);
      dif.currentFloorButton = (($urandom % 6) == 0) ? 2'($urandom) : 2'b00;
      dif.internalButton = (($urandom % 10) == 0) ? 9'(1 << $urandom_range(0, 8)) : 9'd0;
      dif.obstruction = ($urandom % 12) == 0;
      step();
    end
    clearIn();
    repeat (60) step();

    @(posedge clk);
    #2;
    check("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/door_controller.md
# door_controller

Parametrised car-door controller for the N-floor elevator. It sits between the motion/dispatch logic and the door actuator. It opens the door on a matching hall call, a car call or the open button at the current floor, then holds the door for a dwell time. Door travel is modelled as timed OPENING/CLOSING phases, and the door reverses when an obstruction is detected. After repeated reopen attempts it drops into a nudge mode and flags a fault.

## Interface
- FLOORS, 7, number of served floors (≥2)
- FLOOR_W, 3, width of floor index (2^FLOOR_W > FLOORS)
- CLK_PER_OPEN, 500000000, dwell cycles in OPEN (≥1)
- CLK_PER_MOVE, 50000000, door travel cycles for OPENING and CLOSING (≥1)
- MAX_REOPEN, 3, reopen count that triggers nudge/fault (≥1)

- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- moving  in  1  car in motion; opening is blocked while high
- currentFloor  in  FLOOR_W  current floor, 1-based (1..FLOORS)
- currentDirection  in  2  STOP=00, UP=10, DOWN=01, UPDOWN=11
- currentFloorButton  in  2  hall calls at current floor, {up,down}
- internalButton  in  FLOORS+2  [FLOORS:1] car calls; [FLOORS+1] CLOSE; [FLOORS+2] OPEN
- obstruction  in  1  door-edge sensor, level
- doorState  out  1  1 whenever doorPhase != CLOSED (motion interlock)
- doorPhase  out  2  CLOSED=00, OPENING=01, OPEN=10, CLOSING=11
- serviced  out  1  one-cycle pulse on entry to OPEN (clear calls at this floor)
- fault  out  1  nudge mode active

## Operation
- Internal signals: 32-bit down-counter `timer`, and a reopen counter wide enough for MAX_REOPEN that saturates at MAX_REOPEN.
- `call` = (currentDirection != STOP && (currentFloorButton & currentDirection) != 0) || internalButton[currentFloor].
- `openReq` = call || internalButton[FLOORS+2].
- `closeReq` = internalButton[FLOORS+1].
- An out-of-range currentFloor (0 or >FLOORS) contributes no car call.
- CLOSED:
  - openReq && !moving → OPENING, timer = CLK_PER_MOVE−1.
  - Otherwise stay in CLOSED.
- OPENING:
  - Counts down.
  - At timer==0 → OPEN, timer = CLK_PER_OPEN−1, pulse serviced.
  - Requests are ignored during this phase.
- OPEN, priority order:
  1. obstruction or openReq → timer = CLK_PER_OPEN−1.
  2. closeReq → CLOSING, timer = CLK_PER_MOVE−1.
  3. timer==0 → CLOSING, timer = CLK_PER_MOVE−1.
  4. Otherwise timer−1.
- CLOSING, normal mode (fault=0):
  - obstruction or openReq → OPENING, timer = CLK_PER_MOVE−1−timer (reverse the travel already done).
  - On that reopen, the reopen counter increments. Reaching MAX_REOPEN sets fault in the same cycle.
- CLOSING, nudge mode (fault=1):
  - openReq is ignored.
  - obstruction holds the timer (pause) and does not reverse.
- CLOSING, common: timer==0 with no reversal or pause → CLOSED. The reopen counter and fault clear on that entry.
- moving is only sampled in CLOSED. Assertion of moving in any other phase is a system protocol error and is ignored.
- reset, at any time and in any phase: doorPhase=CLOSED, doorState=0, serviced=0, fault=0, timer=0, reopen counter=0. A door in mid-travel is treated as closed; this is an actuator-side safety responsibility.

## Timing
- Request sampled in CLOSED at edge n:
  - doorPhase=OPENING after edge n.
  - doorPhase=OPEN and serviced=1 after edge n+CLK_PER_MOVE.
  - serviced=0 after edge n+CLK_PER_MOVE+1.
- Undisturbed cycle lengths:
  - OPEN lasts CLK_PER_OPEN cycles.
  - CLOSING lasts CLK_PER_MOVE cycles.
  - Total CLOSED→CLOSED = 2·CLK_PER_MOVE + CLK_PER_OPEN cycles.
- closeReq in OPEN: CLOSING after the next edge.
- Reversal at CLOSING timer=t: OPENING lasts CLK_PER_MOVE−t cycles.
- Outputs are registered. doorState is combinationally derived from the doorPhase register.
- Simultaneous events:
  - obstruction + closeReq in OPEN → obstruction wins.
  - openReq + moving in CLOSED → stays CLOSED.
  - Reversal and reopen-counter saturation in the same cycle → reversal happens, and nudge applies from the next CLOSING.

## Test plan
Parameters for all scenarios: FLOORS=7, CLK_PER_OPEN=8, CLK_PER_MOVE=4, MAX_REOPEN=2.

1. Car call: currentFloor=3, internalButton[3]=1, moving=0 → OPENING 4 cycles, one serviced pulse, OPEN 8 cycles, CLOSING 4 cycles, CLOSED; doorState high for exactly 16 cycles.
2. Hall match vs mismatch:
   - currentDirection=UP, currentFloorButton=01 → no open.
   - currentFloorButton=10 → opens.
   - currentDirection=STOP, currentFloorButton=11 → no open.
3. Buttons:
   - Open button held in OPEN for 20 cycles → stays OPEN for 20+8 cycles.
   - Close pulse at the 2nd OPEN cycle → CLOSING on the next cycle.
   - moving=1 with a car call in CLOSED → stays CLOSED.
4. Reversal: obstruction for 1 cycle at CLOSING timer=1 → OPENING lasting 3 cycles; serviced pulses again on re-entry to OPEN.
5. Nudge: obstruction at each CLOSING, twice → fault=1 on the 2nd reversal. Next CLOSING with obstruction held 5 cycles → timer pauses, no reversal; open button ignored. CLOSED reached 4 active cycles later; fault=0 on entry.
6. Reset mid-OPENING and mid-CLOSING → next cycle doorPhase=00, all outputs 0. A subsequent car call opens with full 4-cycle timing.
